// File: rtl/register_16.sv
// register_16: parameterizable synchronous data register.
// DEPTH cascaded stages of WIDTH bits.
// Each stage loads RESET_VALUE on a reset edge, otherwise it shifts forward by one stage.
// The output q comes straight from the last stage, so there is no combinational path from d to q.
module register_16 #(
  parameter int               WIDTH       = 16,
  parameter int               DEPTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Stage storage: r_stage[0] is nearest d, r_stage[DEPTH-1] drives q.
  logic [WIDTH-1:0] r_stage [DEPTH];

  // First stage captures the input word every edge unless reset is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage[0] <= RESET_VALUE;
    end else begin
      r_stage[0] <= d;
    end
  end

  // Remaining stages each take the previous stage's word.
  // A reset clears every in-flight stage on the same edge.
  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
    // Shift stage gi-1 into stage gi.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_stage[gi] <= RESET_VALUE;
      end else begin
        r_stage[gi] <= r_stage[gi-1];
      end
    end
  end

  assign q = r_stage[DEPTH-1];

endmodule

// File: tb/tb_register_16.sv
// Directed bench for register_16.
// Covers the default configuration (16 bits, one stage, zero reset value)
// and an 8-bit, three-stage variant whose reset value is 8'h5A.
`timescale 1ns/1ps
module tb_register_16;

  logic        clk;
  logic        reset;
  logic [15:0] d;
  logic [15:0] q;

  logic        reset_v;
  logic [7:0]  d_v;
  logic [7:0]  q_v;

  int checks;
  int failures;

  register_16 dut (
    .clk   (clk),
    .reset (reset),
    .d     (d),
    .q     (q)
  );

  register_16 #(
    .WIDTH       (8),
    .DEPTH       (3),
    .RESET_VALUE (8'h5A)
  ) dut_v (
    .clk   (clk),
    .reset (reset_v),
    .d     (d_v),
    .q     (q_v)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ns, and so on.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h expected=%h", tag, $time, obs, exp);
    end else begin
      $display("ok   %s t=%0t value=%h", tag, $time, obs);
    end
  endtask

  // Advance to an absolute simulation time in ns.
  task automatic at(input int t);
    #(t - $time);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    d        = 16'h0000;
    reset_v  = 1'b1;
    d_v      = 8'h00;

    // Reset: d=FFFF while reset is high must not reach q.
    at(2);  d = 16'hFFFF;
    at(8);  check_eq("reset_q_zero", {48'h0, q}, 64'h0000);
    at(9);  d = 16'h0000;
    at(10); reset = 1'b0;
    at(14); check_eq("reset_hold_before_load", {48'h0, q}, 64'h0000);

    // Load: q stays zero until the 25 ns edge, then shows AAAA.
    at(19); check_eq("load_pre_edge", {48'h0, q}, 64'h0000);
    at(20); d = 16'hAAAA;
    at(24); check_eq("load_not_yet", {48'h0, q}, 64'h0000);
    at(26); check_eq("load_aaaa", {48'h0, q}, 64'hAAAA);

    // Sequence: F0F0 then 0F0F, then q holds 0F0F through 60 ns.
    at(30); d = 16'hF0F0;
    at(36); check_eq("seq_f0f0", {48'h0, q}, 64'hF0F0);
    at(40); d = 16'h0F0F;
    at(46); check_eq("seq_0f0f", {48'h0, q}, 64'h0F0F);
    at(56); check_eq("seq_hold_56", {48'h0, q}, 64'h0F0F);

    // Mid-cycle glitch: d toggles between edges, and q changes only at the 65 ns edge.
    at(60); d = 16'h1234;
    at(61); d = 16'h5678;
    at(62); d = 16'h1234;
    at(63); d = 16'h5678;
    at(64); check_eq("glitch_stable", {48'h0, q}, 64'h0F0F);
    at(66); check_eq("glitch_edge", {48'h0, q}, 64'h5678);

    // Reset mid-operation: q=0F0F, then one reset edge clears it, then loading resumes.
    at(70); d = 16'h0F0F;
    at(76); check_eq("midrst_pre", {48'h0, q}, 64'h0F0F);
    at(80); reset = 1'b1; d = 16'hABCD;
    at(86); check_eq("midrst_clear", {48'h0, q}, 64'h0000);
    at(90); reset = 1'b0;
    at(96); check_eq("midrst_resume", {48'h0, q}, 64'hABCD);

    // Parameter variant: reset has been held since t=0, and it is released at 110 ns.
    at(106); check_eq("var_reset", {56'h0, q_v}, 64'h5A);
    at(110); reset_v = 1'b0; d_v = 8'h11;
    at(116); check_eq("var_edge1", {56'h0, q_v}, 64'h5A);
    at(120); d_v = 8'h22;
    at(126); check_eq("var_edge2", {56'h0, q_v}, 64'h5A);
    at(130); d_v = 8'h33;
    at(136); check_eq("var_edge3", {56'h0, q_v}, 64'h11);
    at(146); check_eq("var_edge4", {56'h0, q_v}, 64'h22);
    at(156); check_eq("var_edge5", {56'h0, q_v}, 64'h33);

    // Variant mid-operation reset clears all three stages in a single edge.
    at(160); reset_v = 1'b1; d_v = 8'h44;
    at(166); check_eq("var_midrst", {56'h0, q_v}, 64'h5A);
    at(170); reset_v = 1'b0;
    at(176); check_eq("var_after_rst1", {56'h0, q_v}, 64'h5A);
    at(186); check_eq("var_after_rst2", {56'h0, q_v}, 64'h5A);
    at(196); check_eq("var_after_rst3", {56'h0, q_v}, 64'h44);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
